// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and constants for the MIPS memory-stage access controller.
//   state_t          : controller states (IDLE, ACCESS)
//   REG_ADDR_W       : register-file address width
//   DATA_W_DEFAULT   : default data/address width
//   ERR_*            : error codes; bit 0 = access error, bit 1 = timeout
//   cmd_illegal()    : true when a memory command cannot be issued
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_ADDR_W     = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // One bit per error so the error register maps straight onto the
    // two error pulse outputs.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ACCESS  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // A command is illegal if it asks for both a load and a store, or if
    // the word address is not 4-byte aligned.
    function automatic logic cmd_illegal(input logic       rd_cmd,
                                         input logic       wr_cmd,
                                         input logic [1:0] addr_lsb);
        return (rd_cmd && wr_cmd) || (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_timeout_ctr
// Counts request cycles that pass without an acknowledge.
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   clear    in  force the count to zero (wins over enable)
//   enable   in  increment the count this cycle
//   terminal out count has reached TIMEOUT-1 (last allowed request cycle)
// ---------------------------------------------------------------------------
module mem_timeout_ctr #(
    parameter  int TIMEOUT = 15,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage access controller: turns load/store commands into req/ack
// transactions on a variable-latency data memory, stalls the pipeline while
// a transaction is outstanding, and presents a registered writeback bundle.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   in_valid, memread, memwrite,
//   memtoreg, reg_write,
//   alu_result, store_data, rd   instruction from the execute stage
//   stall                        upstream must hold its instruction
//   mem_req, mem_we, mem_addr,
//   mem_wdata                    data-memory request (held while mem_req)
//   mem_ack, mem_rdata           one-cycle completion pulse and read data
//   wb_valid, wb_reg_write,
//   wb_rd, wb_data               writeback bundle (wb_valid is a pulse)
//   access_err, timeout_err      one-cycle error pulses
//
// Handshake: mem_req rises the cycle after a legal command is accepted and
// stays high, with mem_we/mem_addr/mem_wdata frozen, until a cycle in which
// mem_ack is sampled high (the transfer completes in that cycle) or until
// TIMEOUT request cycles have passed without it. mem_ack is ignored whenever
// no request is outstanding. in_valid is only looked at while stall is low.
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic                  memtoreg,
    input  logic                  reg_write,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  access_err,
    output logic                  timeout_err
);

    state_t                state;
    logic                  memtoreg_q;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [1:0]            err_q;
    logic                  in_access;
    logic                  ctr_clear;
    logic                  tc_hit;

    assign in_access = (state == ACCESS);
    // The counter only runs inside ACCESS and restarts on every exit, so
    // each transaction sees a fresh count from its first request cycle.
    assign ctr_clear = !in_access || mem_ack || tc_hit;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    (ctr_clear),
        .enable   (in_access),
        .terminal (tc_hit)
    );

    // The error register bits are the error outputs themselves.
    assign {timeout_err, access_err} = err_q;

    // mem_addr, mem_wdata and mem_we double as the latched alu_result,
    // store_data and memwrite for the duration of the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            stall        <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            err_q        <= ERR_NONE;
            memtoreg_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            err_q        <= ERR_NONE;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!memread && !memwrite) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= alu_result;
                            wb_reg_write <= reg_write;
                            wb_rd        <= rd;
                        end else if (cmd_illegal(memread, memwrite, alu_result[1:0])) begin
                            wb_valid <= 1'b1;
                            wb_data  <= '0;
                            wb_rd    <= rd;
                            err_q    <= ERR_ACCESS;
                        end else begin
                            mem_we      <= memwrite;
                            mem_addr    <= alu_result;
                            mem_wdata   <= store_data;
                            memtoreg_q  <= memtoreg;
                            reg_write_q <= reg_write;
                            rd_q        <= rd;
                            mem_req     <= 1'b1;
                            stall       <= 1'b1;
                            state       <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    // Acknowledge takes priority over the timeout on the
                    // last allowed request cycle.
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        stall        <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_data      <= memtoreg_q ? mem_rdata : mem_addr;
                        wb_reg_write <= reg_write_q;
                        wb_rd        <= rd_q;
                        state        <= IDLE;
                    end else if (tc_hit) begin
                        mem_req  <= 1'b0;
                        stall    <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_data  <= '0;
                        wb_rd    <= rd_q;
                        err_q    <= ERR_TIMEOUT;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed scenarios plus a randomized run checked against a transaction-
// level reference model. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int DATA_W   = 32;
    localparam int TIMEOUT  = 15;
    localparam int LOOP_MAX = TIMEOUT + 4;
    localparam int OUTS_W   = 3 + 2 * DATA_W + 2 + 5 + DATA_W + 2;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, memread, memwrite, memtoreg, reg_write;
    logic [DATA_W-1:0] alu_result, store_data;
    logic [4:0]        rd;
    logic              stall, mem_req, mem_we;
    logic [DATA_W-1:0] mem_addr, mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid, wb_reg_write;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              access_err, timeout_err;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .memread      (memread),
        .memwrite     (memwrite),
        .memtoreg     (memtoreg),
        .reg_write    (reg_write),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd           (rd),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .access_err   (access_err),
        .timeout_err  (timeout_err)
    );

    // ---------------- types, model, scoreboard ----------------
    typedef struct {
        logic              rd_c;
        logic              wr_c;
        logic              m2r;
        logic              rw;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] sdata;
        logic [4:0]        rd;
    } op_t;

    typedef struct {
        int                req_cycles;
        logic              stall;
        logic              mem_req;
        logic              wb_valid;
        logic              wb_reg_write;
        logic              access_err;
        logic              timeout_err;
        logic [DATA_W-1:0] wb_data;
        logic [4:0]        wb_rd;
        logic              stable;
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              early_pulse;
    } obs_t;

    typedef struct {
        int                req_cycles;
        logic              wb_reg_write;
        logic              access_err;
        logic              timeout_err;
        logic              data_known;
        logic [DATA_W-1:0] wb_data;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];

    // Outcome of one instruction given how the memory behaves: ack_at is the
    // request cycle (1-based) on which memory acknowledges, 0 for never.
    function automatic exp_t model(input op_t op, input int ack_at, input logic [DATA_W-1:0] rdata);
        exp_t e;
        e.req_cycles   = 0;
        e.wb_reg_write = 1'b0;
        e.access_err   = 1'b0;
        e.timeout_err  = 1'b0;
        e.data_known   = 1'b0;
        e.wb_data      = '0;
        if (!op.rd_c && !op.wr_c) begin
            e.wb_reg_write = op.rw;
            e.wb_data      = op.addr;
            e.data_known   = 1'b1;
        end else if ((op.rd_c && op.wr_c) || (op.addr % 4 != 0)) begin
            e.access_err = 1'b1;
        end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
            e.req_cycles   = ack_at;
            e.wb_reg_write = op.rw;
            e.wb_data      = op.m2r ? rdata : op.addr;
            e.data_known   = 1'b1;
        end else begin
            e.req_cycles  = TIMEOUT;
            e.timeout_err = 1'b1;
        end
        return e;
    endfunction

    function automatic op_t make_op(input logic rd_c, input logic wr_c, input logic m2r,
                                    input logic rw, input logic [DATA_W-1:0] addr,
                                    input logic [DATA_W-1:0] sdata, input logic [4:0] rdst);
        op_t op;
        op.rd_c  = rd_c;
        op.wr_c  = wr_c;
        op.m2r   = m2r;
        op.rw    = rw;
        op.addr  = addr;
        op.sdata = sdata;
        op.rd    = rdst;
        return op;
    endfunction

    function automatic logic [OUTS_W-1:0] outs_all();
        return {stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_reg_write,
                wb_rd, wb_data, access_err, timeout_err};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        in_valid   = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        reg_write  = 1'b0;
        alu_result = '0;
        store_data = '0;
        rd         = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic present(input op_t op);
        in_valid   = 1'b1;
        memread    = op.rd_c;
        memwrite   = op.wr_c;
        memtoreg   = op.m2r;
        reg_write  = op.rw;
        alu_result = op.addr;
        store_data = op.sdata;
        rd         = op.rd;
    endtask

    // Presents one instruction, plays the memory side (ack on request cycle
    // ack_at, 0 = never) while offering junk instructions during the stall,
    // and returns what was seen, ending on the writeback cycle.
    task automatic run_op(input op_t op, input int ack_at, input logic [DATA_W-1:0] rdata,
                          output obs_t o);
        present(op);
        tick();
        in_valid = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        o.req_cycles  = 0;
        o.stable      = 1'b1;
        o.we          = 1'b0;
        o.addr        = '0;
        o.wdata       = '0;
        o.early_pulse = mem_req & (wb_valid | access_err | timeout_err);
        while (mem_req === 1'b1 && o.req_cycles < LOOP_MAX) begin
            o.req_cycles = o.req_cycles + 1;
            if (o.req_cycles == 1) begin
                o.we    = mem_we;
                o.addr  = mem_addr;
                o.wdata = mem_wdata;
            end else if ({mem_we, mem_addr, mem_wdata} !== {o.we, o.addr, o.wdata}) begin
                o.stable = 1'b0;
            end
            if (stall !== 1'b1) o.stable = 1'b0;
            in_valid   = 1'b1;
            memread    = 1'($urandom_range(0, 1));
            memwrite   = 1'($urandom_range(0, 1));
            reg_write  = 1'b1;
            alu_result = DATA_W'($urandom);
            mem_ack    = (o.req_cycles == ack_at);
            mem_rdata  = (o.req_cycles == ack_at) ? rdata : DATA_W'($urandom);
            tick();
        end
        in_valid   = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        mem_ack    = 1'b0;
        o.stall        = stall;
        o.mem_req      = mem_req;
        o.wb_valid     = wb_valid;
        o.wb_reg_write = wb_reg_write;
        o.access_err   = access_err;
        o.timeout_err  = timeout_err;
        o.wb_data      = wb_data;
        o.wb_rd        = wb_rd;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst        = 1'b1;
        in_valid   = 1'b1;
        memread    = 1'b1;
        alu_result = 32'h100;
        mem_ack    = 1'b1;
        tick();
        tick();
        checks++;
        if (outs_all() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", outs_all());
        end
        rst = 1'b0;
        drive_idle();
        tick();
        checks++;
        if (outs_all() !== '0) begin
            failures++;
            $display("FAIL reset_idle_outputs: got %h expected 0", outs_all());
        end
    endtask

    task automatic test_passthrough();
        obs_t o;
        run_op(make_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00AA, 32'h0, 5'd5), 0, '0, o);
        checks++;
        if (o.req_cycles !== 0) begin
            failures++;
            $display("FAIL pass_mem_req: got %0d request cycles expected 0", o.req_cycles);
        end
        checks++;
        if ({o.wb_valid, o.wb_reg_write, o.wb_rd, o.wb_data} !== {1'b1, 1'b1, 5'd5, 32'hAA}) begin
            failures++;
            $display("FAIL pass_wb: got v=%b we=%b rd=%0d data=%h expected v=1 we=1 rd=5 data=000000aa",
                     o.wb_valid, o.wb_reg_write, o.wb_rd, o.wb_data);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL pass_wb_pulse: got wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_load();
        obs_t o;
        run_op(make_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd9), 3, 32'hDEAD_BEEF, o);
        checks++;
        if (o.req_cycles !== 3 || o.stable !== 1'b1) begin
            failures++;
            $display("FAIL load_stall: got %0d cycles stable=%b expected 3 cycles stable=1",
                     o.req_cycles, o.stable);
        end
        checks++;
        if ({o.we, o.addr, o.early_pulse} !== {1'b0, 32'h100, 1'b0}) begin
            failures++;
            $display("FAIL load_req: got we=%b addr=%h early=%b expected we=0 addr=00000100 early=0",
                     o.we, o.addr, o.early_pulse);
        end
        checks++;
        if ({o.stall, o.mem_req, o.wb_valid, o.wb_reg_write, o.wb_rd, o.wb_data} !==
            {1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL load_wb: got stall=%b req=%b v=%b we=%b rd=%0d data=%h expected 0 0 1 1 9 deadbeef",
                     o.stall, o.mem_req, o.wb_valid, o.wb_reg_write, o.wb_rd, o.wb_data);
        end
    endtask

    task automatic test_store();
        obs_t o;
        run_op(make_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h1234, 5'd0), 1, 32'h5555_5555, o);
        checks++;
        if ({o.we, o.addr, o.wdata} !== {1'b1, 32'h204, 32'h1234}) begin
            failures++;
            $display("FAIL store_req: got we=%b addr=%h wdata=%h expected 1 00000204 00001234",
                     o.we, o.addr, o.wdata);
        end
        checks++;
        if (o.req_cycles !== 1 || o.wb_valid !== 1'b1 || o.wb_reg_write !== 1'b0) begin
            failures++;
            $display("FAIL store_wb: got cycles=%0d v=%b we=%b expected 1 1 0",
                     o.req_cycles, o.wb_valid, o.wb_reg_write);
        end
    endtask

    task automatic test_access_err();
        obs_t o;
        op_t  ops[2];
        ops[0] = make_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd3);
        ops[1] = make_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h7, 5'd4);
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], 1, 32'h1, o);
            checks++;
            if ({o.req_cycles != 0, o.access_err, o.timeout_err, o.wb_valid, o.wb_reg_write} !==
                5'b0_1_0_1_0) begin
                failures++;
                $display("FAIL access_err_%0d: got cycles=%0d aerr=%b terr=%b v=%b we=%b expected 0 1 0 1 0",
                         i, o.req_cycles, o.access_err, o.timeout_err, o.wb_valid, o.wb_reg_write);
            end
            tick();
            checks++;
            if ({access_err, wb_valid, mem_req} !== 3'b000) begin
                failures++;
                $display("FAIL access_err_pulse_%0d: got aerr=%b v=%b req=%b expected 000",
                         i, access_err, wb_valid, mem_req);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_op(make_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd6), 0, '0, o);
        checks++;
        if (o.req_cycles !== TIMEOUT) begin
            failures++;
            $display("FAIL timeout_len: got %0d request cycles expected %0d", o.req_cycles, TIMEOUT);
        end
        checks++;
        if ({o.timeout_err, o.access_err, o.stall, o.mem_req, o.wb_valid, o.wb_reg_write} !== 6'b100010) begin
            failures++;
            $display("FAIL timeout_wb: got terr=%b aerr=%b stall=%b req=%b v=%b we=%b expected 1 0 0 0 1 0",
                     o.timeout_err, o.access_err, o.stall, o.mem_req, o.wb_valid, o.wb_reg_write);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got %b expected 0", timeout_err);
        end
        run_op(make_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 5'd6), TIMEOUT, 32'hCAFE_F00D, o);
        checks++;
        if ({o.timeout_err, o.wb_valid, o.wb_reg_write, o.wb_data} !== {1'b0, 1'b1, 1'b1, 32'hCAFE_F00D} ||
            o.req_cycles !== TIMEOUT) begin
            failures++;
            $display("FAIL timeout_ack_wins: got cycles=%0d terr=%b v=%b we=%b data=%h expected %0d 0 1 1 cafef00d",
                     o.req_cycles, o.timeout_err, o.wb_valid, o.wb_reg_write, o.wb_data, TIMEOUT);
        end
    endtask

    task automatic test_reset_in_access();
        obs_t o;
        present(make_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd7));
        tick();
        in_valid = 1'b0;
        memread  = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_access_entry: got mem_req=%b expected 1", mem_req);
        end
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        checks++;
        if (outs_all() !== '0) begin
            failures++;
            $display("FAIL rst_access_abort: got %h expected 0", outs_all());
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (outs_all() !== '0) begin
            failures++;
            $display("FAIL rst_late_ack: got %h expected 0", outs_all());
        end
        run_op(make_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h308, 32'h0, 5'd8), 2, 32'h0BAD_F00D, o);
        checks++;
        if ({o.wb_valid, o.wb_reg_write, o.wb_rd, o.wb_data} !== {1'b1, 1'b1, 5'd8, 32'h0BAD_F00D} ||
            o.req_cycles !== 2) begin
            failures++;
            $display("FAIL rst_next_load: got cycles=%0d v=%b we=%b rd=%0d data=%h expected 2 1 1 8 0badf00d",
                     o.req_cycles, o.wb_valid, o.wb_reg_write, o.wb_rd, o.wb_data);
        end
    endtask

    // Random mix of pass-through, load, store and illegal ops, random ack
    // latency (including none), stray acks while idle and back-to-back issue.
    task automatic test_random(input int n);
        op_t               op;
        obs_t              o;
        exp_t              e;
        int                kind;
        int                ack_at;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] exp_d;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = DATA_W'($urandom);
                tick();
                mem_ack = 1'b0;
                checks++;
                if ({wb_valid, mem_req, stall, access_err, timeout_err} !== 5'b0) begin
                    failures++;
                    $display("FAIL rand_idle_ack[%0d]: got v=%b req=%b stall=%b aerr=%b terr=%b expected all 0",
                             i, wb_valid, mem_req, stall, access_err, timeout_err);
                end
            end
            kind = $urandom_range(0, 9);
            op   = make_op(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           DATA_W'($urandom) & 32'hFFFF_FFFC, DATA_W'($urandom), 5'($urandom_range(0, 31)));
            case (kind)
                0, 1:       op.addr = DATA_W'($urandom);
                2, 3, 4, 5: op.rd_c = 1'b1;
                6, 7:       begin op.wr_c = 1'b1; op.m2r = 1'b0; end
                8:          begin op.rd_c = 1'b1; op.wr_c = 1'b1; end
                default: begin
                    op.rd_c = 1'($urandom_range(0, 1));
                    op.wr_c = ~op.rd_c;
                    op.addr = op.addr | DATA_W'($urandom_range(1, 3));
                end
            endcase
            ack_at = ($urandom_range(0, 7) == 0) ? 0 :
                     ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(1, TIMEOUT);
            rdata = DATA_W'($urandom);
            e = model(op, ack_at, rdata);
            if (e.data_known) exp_q.push_back(e.wb_data);
            run_op(op, ack_at, rdata, o);
            checks++;
            if (o.req_cycles !== e.req_cycles) begin
                failures++;
                $display("FAIL rand_req_cycles[%0d]: got %0d expected %0d", i, o.req_cycles, e.req_cycles);
            end
            checks++;
            if ({o.stall, o.mem_req, o.wb_valid, o.wb_reg_write, o.access_err, o.timeout_err} !==
                {2'b00, 1'b1, e.wb_reg_write, e.access_err, e.timeout_err}) begin
                failures++;
                $display("FAIL rand_wb_ctl[%0d]: got %b expected %b", i,
                         {o.stall, o.mem_req, o.wb_valid, o.wb_reg_write, o.access_err, o.timeout_err},
                         {2'b00, 1'b1, e.wb_reg_write, e.access_err, e.timeout_err});
            end
            if (e.data_known) begin
                exp_d = exp_q.pop_front();
                checks++;
                if ({o.wb_data, o.wb_rd} !== {exp_d, op.rd}) begin
                    failures++;
                    $display("FAIL rand_wb_data[%0d]: got data=%h rd=%0d expected data=%h rd=%0d",
                             i, o.wb_data, o.wb_rd, exp_d, op.rd);
                end
            end
            if (e.req_cycles > 0) begin
                checks++;
                if ({o.stable, o.early_pulse, o.we, o.addr, o.wdata} !==
                    {1'b1, 1'b0, op.wr_c, op.addr, op.sdata}) begin
                    failures++;
                    $display("FAIL rand_mem_port[%0d]: got stable=%b early=%b we=%b addr=%h wdata=%h expected 1 0 %b %h %h",
                             i, o.stable, o.early_pulse, o.we, o.addr, o.wdata, op.wr_c, op.addr, op.sdata);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_access_err();
        test_timeout();
        test_reset_in_access();
        test_random(60);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the report");
        $fatal(1);
    end

endmodule
